writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage. It sits directly downstream of the execute stage and consumes its 16-bit result and its four flags.
- Commits the result to the register file (rd, plus rd+1 for wide results) or to data memory. Latches the architectural flag register.
- Resolves jumps and branches into a PC load, and enters a sticky halt state.
- One instruction at a time, with a valid/ready handshake toward execute.

Parameters:
- COUNT_W, 8, width of the retired-instruction counter.
- HALT_OPCODE, 5'b11111, opcode that enters the halt state.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  execute presents a finished instruction
- in_ready  output  1  stage can accept this cycle (combinational from state)
- opcode  input  5  instruction opcode
- am  input  1  addressing mode (0 = register, 1 = memory)
- rd  input  3  destination register
- mem_addr  input  4  data-memory address
- instr_mem_addr  input  6  jump/branch target
- result  input  16  execute result; [7:0] low byte, [15:8] high byte (mul product high / div remainder)
- zero_flag, carry_flag, ac_flag, parity_flag  input  1 each  flags from execute
- reg_we  output  1  register-file write strobe
- reg_waddr  output  3  register write address
- reg_wdata  output  8  register write data
- mem_we  output  1  data-memory write strobe
- mem_waddr  output  4  memory write address
- mem_wdata  output  8  memory write data
- flags_q  output  4  committed flags {Z,C,AC,P}
- pc_load  output  1  one-cycle PC redirect strobe
- pc_target  output  6  redirect address
- halted  output  1  halt state reached
- retired  output  COUNT_W  count of committed instructions

Behaviour:
- Reset (async, active-high): all outputs and internal registers go to 0; state goes to IDLE. Any pending high-byte write is dropped. reset overrides every other input.
- States: IDLE, COMMIT, COMMIT_HI, HALT.
- accept = valid_in & in_ready.
- in_ready = 0 in HALT, and 0 in COMMIT when the held op is wide (00011 or 00100). It is 1 otherwise.
- Transitions:
  - IDLE: accept -> COMMIT, or HALT if opcode == HALT_OPCODE.
  - COMMIT with a wide op -> COMMIT_HI.
  - COMMIT with any other op, and COMMIT_HI: accept -> COMMIT/HALT, otherwise -> IDLE.
  - HALT: held until reset; inputs are ignored.
- Latency: all outputs are registered. Strobes rise in the cycle after the accept edge and last exactly 1 cycle per write. Back-to-back accepts give back-to-back strobes.
- Destination rules:
  - Opcodes 00000, 00001, 00010, 00111, 01000, 01010, 01011: reg write, rd <= result[7:0].
  - 00011 and 00100: COMMIT writes rd <= result[7:0]; COMMIT_HI writes (rd+1) mod 8 <= result[15:8]. 3'b111 wraps to 3'b000.
  - 00101, 00110, 01001, 10000-10101: am=0 -> reg rd; am=1 -> mem[mem_addr]. Data is result[7:0].
  - 01100: mem[mem_addr] <= result[7:0].
  - 01101 (jump): pc_load=1, pc_target=instr_mem_addr. No writes.
  - Branches are taken on: 01110 Z=1, 10110 C=1, 10111 Z=0, 11000 P=1. Taken -> pc_load=1 with pc_target=instr_mem_addr. Not taken -> no strobe.
  - 11001 (compare): no write; flags only.
  - Undefined opcodes (01111, 11010-11110): NOP. No writes and no flag change, but retired still increments.
- Flags:
  - flags_q loads {zero,carry,ac,parity} at the accept edge for opcodes 00001-01010, 10000-10101 and 11001. All other opcodes leave it unchanged.
  - A branch evaluates flags_q as held before its own accept edge. This is the value committed by the previous accepted instruction; no bypass is needed.
- Outputs while idle or not writing:
  - When a strobe is 0, reg_waddr/reg_wdata/mem_waddr/mem_wdata/pc_target hold their last values.
  - No simultaneous reg_we and mem_we.
- retired:
  - Increments by 1 per accepted non-halt instruction, at the accept edge. Wide ops count once.
  - Wraps from all-ones to 0.
- halted is 1 from the cycle after HALT_OPCODE is accepted until reset.

Test Plan:
- Reset released; add with result=16'h0012, rd=3, Z/C/AC/P=0,0,0,0 -> next cycle reg_we=1, waddr=3, wdata=8'h12; flags_q=4'b0000; retired=1.
- Mul, rd=7, result=16'h1234 -> cycle+1: reg 7 <= 8'h34 with in_ready=0; cycle+2: reg 0 <= 8'h12. A valid_in held during cycle+1 is accepted only at the end of cycle+2.
- Decrement, am=1, mem_addr=4'hA, result=8'hFF -> mem_we=1 with waddr=A, wdata=FF; reg_we=0.
- Sub setting Z=1, then branch 01110 with target 6'h2C, back-to-back -> pc_load=1 with target 2C. Repeat with Z=0 committed first -> no pc_load.
- Reset asserted during the COMMIT cycle of a div -> outputs 0 immediately; no high-byte write occurs; state is IDLE.
- Halt accepted -> halted=1 next cycle; later valid_in with add -> no strobes; retired unchanged.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Execute-to-writeback channel: finished instruction, its result and flags, plus the ready back-pressure.
// valid_in/in_ready: a transfer happens on a rising edge where both are 1; the payload must be stable while valid_in is 1.
interface writeback_stage_if;
    logic        valid_in;
    logic        in_ready;
    logic [4:0]  opcode;
    logic        am;
    logic [2:0]  rd;
    logic [3:0]  mem_addr;
    logic [5:0]  instr_mem_addr;
    logic [15:0] result;
    logic        zero_flag;
    logic        carry_flag;
    logic        ac_flag;
    logic        parity_flag;

    modport master (
        output valid_in, opcode, am, rd, mem_addr, instr_mem_addr, result,
               zero_flag, carry_flag, ac_flag, parity_flag,
        input  in_ready
    );

    modport slave (
        input  valid_in, opcode, am, rd, mem_addr, instr_mem_addr, result,
               zero_flag, carry_flag, ac_flag, parity_flag,
        output in_ready
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits results to registers or memory, latches flags,
// resolves jumps/branches into a PC redirect and holds a sticky halt.
module writeback_stage #(
    parameter int         COUNT_W     = 8,
    parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
    input  logic               clk,
    input  logic               reset,
    writeback_stage_if.slave   ex,
    output logic               reg_we,
    output logic [2:0]         reg_waddr,
    output logic [7:0]         reg_wdata,
    output logic               mem_we,
    output logic [3:0]         mem_waddr,
    output logic [7:0]         mem_wdata,
    output logic [3:0]         flags_q,
    output logic               pc_load,
    output logic [5:0]         pc_target,
    output logic               halted,
    output logic [COUNT_W-1:0] retired,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMMIT    = 2'd1,
        COMMIT_HI = 2'd2,
        HALT      = 2'd3
    } state_t;

    state_t     state;
    logic       hi_pending;
    logic [2:0] hi_addr;
    logic [7:0] hi_data;

    logic accept;
    logic dec_reg;
    logic dec_mem;
    logic dec_pc;
    logic dec_wide;
    logic dec_flags;

    assign state_dbg   = state;
    assign ex.in_ready = (state != HALT) && !((state == COMMIT) && hi_pending);
    assign accept      = ex.valid_in && ex.in_ready;

    // Branch conditions read the flags committed by the previous instruction.
    always_comb begin
        dec_reg  = 1'b0;
        dec_mem  = 1'b0;
        dec_pc   = 1'b0;
        dec_wide = 1'b0;
        case (ex.opcode) inside
            5'b00000, 5'b00001, 5'b00010, 5'b00111,
            5'b01000, 5'b01010, 5'b01011:              dec_reg = 1'b1;
            5'b00011, 5'b00100: begin
                dec_reg  = 1'b1;
                dec_wide = 1'b1;
            end
            5'b00101, 5'b00110, 5'b01001,
            [5'b10000:5'b10101]: begin
                dec_reg = !ex.am;
                dec_mem = ex.am;
            end
            5'b01100:                                  dec_mem = 1'b1;
            5'b01101:                                  dec_pc  = 1'b1;
            5'b01110:                                  dec_pc  = flags_q[3];
            5'b10110:                                  dec_pc  = flags_q[2];
            5'b10111:                                  dec_pc  = !flags_q[3];
            5'b11000:                                  dec_pc  = flags_q[0];
            default: ;
        endcase
        dec_flags = ex.opcode inside {[5'b00001:5'b01010], [5'b10000:5'b10101], 5'b11001};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hi_pending <= 1'b0;
            hi_addr    <= '0;
            hi_data    <= '0;
            reg_we     <= 1'b0;
            reg_waddr  <= '0;
            reg_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            flags_q    <= '0;
            pc_load    <= 1'b0;
            pc_target  <= '0;
            halted     <= 1'b0;
            retired    <= '0;
        end else begin
            reg_we  <= 1'b0;
            mem_we  <= 1'b0;
            pc_load <= 1'b0;
            if ((state == COMMIT) && hi_pending) begin
                reg_we     <= 1'b1;
                reg_waddr  <= hi_addr;
                reg_wdata  <= hi_data;
                hi_pending <= 1'b0;
                state      <= COMMIT_HI;
            end else if (state != HALT) begin
                if (!accept) begin
                    state <= IDLE;
                end else if (ex.opcode == HALT_OPCODE) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end else begin
                    state      <= COMMIT;
                    retired    <= retired + {{(COUNT_W-1){1'b0}}, 1'b1};
                    hi_pending <= dec_wide;
                    hi_addr    <= ex.rd + 3'd1;
                    hi_data    <= ex.result[15:8];
                    if (dec_flags)
                        flags_q <= {ex.zero_flag, ex.carry_flag, ex.ac_flag, ex.parity_flag};
                    if (dec_reg) begin
                        reg_we    <= 1'b1;
                        reg_waddr <= ex.rd;
                        reg_wdata <= ex.result[7:0];
                    end
                    if (dec_mem) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= ex.mem_addr;
                        mem_wdata <= ex.result[7:0];
                    end
                    if (dec_pc) begin
                        pc_load   <= 1'b1;
                        pc_target <= ex.instr_mem_addr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_writeback_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reg_we, mem_we, pc_load, halted;
    logic [2:0] reg_waddr;
    logic [7:0] reg_wdata, mem_wdata, retired;
    logic [3:0] mem_waddr, flags_q;
    logic [5:0] pc_target;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    writeback_stage_if ex ();

    writeback_stage #(.COUNT_W(8), .HALT_OPCODE(5'b11111)) dut (
        .clk(clk), .reset(reset), .ex(ex),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flags_q(flags_q), .pc_load(pc_load), .pc_target(pc_target),
        .halted(halted), .retired(retired), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags argument is {Z,C,AC,P}
    task automatic drive(input logic v, input logic [4:0] op, input logic a, input logic [2:0] r,
                         input logic [3:0] ma, input logic [5:0] ia, input logic [15:0] res,
                         input logic [3:0] fl);
        ex.valid_in       = v;
        ex.opcode         = op;
        ex.am             = a;
        ex.rd             = r;
        ex.mem_addr       = ma;
        ex.instr_mem_addr = ia;
        ex.result         = res;
        {ex.zero_flag, ex.carry_flag, ex.ac_flag, ex.parity_flag} = fl;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 3'd0, 4'd0, 6'd0, 16'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({reg_we, mem_we, pc_load, halted} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b want 0000", {reg_we, mem_we, pc_load, halted}); end
        checks++; if ({reg_waddr, reg_wdata, mem_waddr, mem_wdata, pc_target} !== 29'd0) begin errors++; $display("FAIL reset_data got %h want 0", {reg_waddr, reg_wdata, mem_waddr, mem_wdata, pc_target}); end
        checks++; if ({flags_q, retired} !== 12'd0) begin errors++; $display("FAIL reset_flags_retired got %h want 0", {flags_q, retired}); end
        checks++; if (ex.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ex.in_ready); end
        reset = 1'b0;
        tick();
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL idle_reg_we got %b want 0", reg_we); end
    endtask

    task automatic test_add();
        drive(1'b1, 5'b00001, 1'b0, 3'd3, 4'd0, 6'd0, 16'h0012, 4'b0000);
        tick();
        drive(1'b0, 5'd0, 1'b0, 3'd0, 4'd0, 6'd0, 16'd0, 4'd0);
        checks++; if ({reg_we, reg_waddr, reg_wdata} !== {1'b1, 3'd3, 8'h12}) begin errors++; $display("FAIL add_write got %h want %h", {reg_we, reg_waddr, reg_wdata}, {1'b1, 3'd3, 8'h12}); end
        checks++; if ({mem_we, flags_q, retired} !== {1'b0, 4'b0000, 8'd1}) begin errors++; $display("FAIL add_state got %h want %h", {mem_we, flags_q, retired}, {1'b0, 4'b0000, 8'd1}); end
        tick();
        checks++; if ({reg_we, reg_waddr, reg_wdata} !== {1'b0, 3'd3, 8'h12}) begin errors++; $display("FAIL add_hold got %h want %h", {reg_we, reg_waddr, reg_wdata}, {1'b0, 3'd3, 8'h12}); end
    endtask

    task automatic test_wide();
        drive(1'b1, 5'b00011, 1'b0, 3'd7, 4'd0, 6'd0, 16'h1234, 4'b0101);
        tick();
        drive(1'b1, 5'b00000, 1'b0, 3'd1, 4'd0, 6'd0, 16'h0055, 4'b1111);
        checks++; if ({reg_we, reg_waddr, reg_wdata} !== {1'b1, 3'd7, 8'h34}) begin errors++; $display("FAIL wide_lo got %h want %h", {reg_we, reg_waddr, reg_wdata}, {1'b1, 3'd7, 8'h34}); end
        checks++; if (ex.in_ready !== 1'b0) begin errors++; $display("FAIL wide_busy got %b want 0", ex.in_ready); end
        checks++; if ({flags_q, retired} !== {4'b0101, 8'd2}) begin errors++; $display("FAIL wide_flags_retired got %h want %h", {flags_q, retired}, {4'b0101, 8'd2}); end
        tick();
        checks++; if ({reg_we, reg_waddr, reg_wdata} !== {1'b1, 3'd0, 8'h12}) begin errors++; $display("FAIL wide_hi got %h want %h", {reg_we, reg_waddr, reg_wdata}, {1'b1, 3'd0, 8'h12}); end
        checks++; if ({ex.in_ready, retired} !== {1'b1, 8'd2}) begin errors++; $display("FAIL wide_hi_ready got %h want %h", {ex.in_ready, retired}, {1'b1, 8'd2}); end
        tick();
        drive(1'b0, 5'd0, 1'b0, 3'd0, 4'd0, 6'd0, 16'd0, 4'd0);
        checks++; if ({reg_we, reg_waddr, reg_wdata, retired} !== {1'b1, 3'd1, 8'h55, 8'd3}) begin errors++; $display("FAIL wide_next got %h want %h", {reg_we, reg_waddr, reg_wdata, retired}, {1'b1, 3'd1, 8'h55, 8'd3}); end
        checks++; if (flags_q !== 4'b0101) begin errors++; $display("FAIL wide_next_flags got %b want 0101", flags_q); end
    endtask

    task automatic test_mem();
        drive(1'b1, 5'b00110, 1'b1, 3'd6, 4'hA, 6'd0, 16'h00FF, 4'b0010);
        tick();
        drive(1'b0, 5'd0, 1'b0, 3'd0, 4'd0, 6'd0, 16'd0, 4'd0);
        checks++; if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 4'hA, 8'hFF}) begin errors++; $display("FAIL mem_write got %h want %h", {mem_we, mem_waddr, mem_wdata}, {1'b1, 4'hA, 8'hFF}); end
        checks++; if ({reg_we, reg_waddr, flags_q, retired} !== {1'b0, 3'd1, 4'b0010, 8'd4}) begin errors++; $display("FAIL mem_side got %h want %h", {reg_we, reg_waddr, flags_q, retired}, {1'b0, 3'd1, 4'b0010, 8'd4}); end
    endtask

    task automatic test_branch();
        drive(1'b1, 5'b00010, 1'b0, 3'd5, 4'd0, 6'd0, 16'h0000, 4'b1000);
        tick();
        drive(1'b1, 5'b01110, 1'b0, 3'd2, 4'd3, 6'h2C, 16'h00AA, 4'b0000);
        checks++; if (flags_q !== 4'b1000) begin errors++; $display("FAIL br_sub_flags got %b want 1000", flags_q); end
        tick();
        drive(1'b1, 5'b00010, 1'b0, 3'd5, 4'd0, 6'd0, 16'h0001, 4'b0000);
        checks++; if ({pc_load, pc_target, reg_we, mem_we} !== {1'b1, 6'h2C, 2'b00}) begin errors++; $display("FAIL br_taken got %h want %h", {pc_load, pc_target, reg_we, mem_we}, {1'b1, 6'h2C, 2'b00}); end
        checks++; if (flags_q !== 4'b1000) begin errors++; $display("FAIL br_keeps_flags got %b want 1000", flags_q); end
        tick();
        drive(1'b1, 5'b01110, 1'b0, 3'd2, 4'd3, 6'h15, 16'h0000, 4'b1000);
        tick();
        drive(1'b1, 5'b10111, 1'b0, 3'd2, 4'd3, 6'h07, 16'h0000, 4'b1111);
        checks++; if ({pc_load, pc_target} !== {1'b0, 6'h2C}) begin errors++; $display("FAIL br_not_taken got %h want %h", {pc_load, pc_target}, {1'b0, 6'h2C}); end
        tick();
        drive(1'b0, 5'd0, 1'b0, 3'd0, 4'd0, 6'd0, 16'd0, 4'd0);
        checks++; if ({pc_load, pc_target, retired} !== {1'b1, 6'h07, 8'd9}) begin errors++; $display("FAIL br_nz_taken got %h want %h", {pc_load, pc_target, retired}, {1'b1, 6'h07, 8'd9}); end
        tick();
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL br_one_cycle got %b want 0", pc_load); end
    endtask

    task automatic test_reset_mid_wide();
        drive(1'b1, 5'b00100, 1'b0, 3'd2, 4'd0, 6'd0, 16'hABCD, 4'b0001);
        tick();
        checks++; if ({reg_we, reg_waddr, reg_wdata} !== {1'b1, 3'd2, 8'hCD}) begin errors++; $display("FAIL div_lo got %h want %h", {reg_we, reg_waddr, reg_wdata}, {1'b1, 3'd2, 8'hCD}); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({reg_we, reg_waddr, reg_wdata, flags_q, retired} !== 24'd0) begin errors++; $display("FAIL div_reset got %h want 0", {reg_we, reg_waddr, reg_wdata, flags_q, retired}); end
        checks++; if (ex.in_ready !== 1'b1) begin errors++; $display("FAIL div_reset_ready got %b want 1", ex.in_ready); end
        #2;
        reset = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 3'd0, 4'd0, 6'd0, 16'd0, 4'd0);
        tick();
        checks++; if ({reg_we, reg_waddr, reg_wdata} !== 12'd0) begin errors++; $display("FAIL div_no_hi got %h want 0", {reg_we, reg_waddr, reg_wdata}); end
    endtask

    task automatic test_random();
        logic [7:0] m_ret;
        logic [3:0] m_flags;
        logic       m_hi;
        logic [2:0] m_hi_a;
        logic [7:0] m_hi_d;
        logic       e_rwe, e_mwe, e_pl, e_ready, acc, taken;
        logic [2:0] e_ra;
        logic [7:0] e_rd, e_md;
        logic [3:0] e_ma;
        logic [5:0] e_pt;
        logic [4:0] op;
        reset = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 3'd0, 4'd0, 6'd0, 16'd0, 4'd0);
        tick();
        reset = 1'b0;
        m_ret = '0; m_flags = '0; m_hi = 1'b0; m_hi_a = '0; m_hi_d = '0;
        e_rwe = 1'b0; e_mwe = 1'b0; e_pl = 1'b0; e_ra = '0; e_rd = '0; e_ma = '0; e_md = '0; e_pt = '0;
        for (int n = 0; n < 400; n++) begin
            op = 5'($urandom_range(0, 30));
            drive(($urandom_range(0, 3) != 0), op, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 16'($urandom_range(0, 65535)),
                  4'($urandom_range(0, 15)));
            #1;
            e_ready = !m_hi;
            checks++; if (ex.in_ready !== e_ready) begin errors++; $display("FAIL rnd_ready n=%0d got %b want %b", n, ex.in_ready, e_ready); end
            acc = ex.valid_in && e_ready;
            e_rwe = 1'b0; e_mwe = 1'b0; e_pl = 1'b0; taken = 1'b0;
            if (m_hi) begin
                e_rwe = 1'b1; e_ra = m_hi_a; e_rd = m_hi_d; m_hi = 1'b0;
            end else if (acc) begin
                m_ret = m_ret + 8'd1;
                if (op inside {0, 1, 2, 3, 4, 7, 8, 10, 11} ||
                    (op inside {5, 6, 9, [16:21]} && !ex.am)) begin
                    e_rwe = 1'b1; e_ra = ex.rd; e_rd = ex.result[7:0];
                end
                if (op == 12 || (op inside {5, 6, 9, [16:21]} && ex.am)) begin
                    e_mwe = 1'b1; e_ma = ex.mem_addr; e_md = ex.result[7:0];
                end
                if (op inside {3, 4}) begin
                    m_hi = 1'b1; m_hi_a = 3'((int'(ex.rd) + 1) % 8); m_hi_d = ex.result[15:8];
                end
                case (op)
                    5'd13: taken = 1'b1;
                    5'd14: taken = m_flags[3];
                    5'd22: taken = m_flags[2];
                    5'd23: taken = !m_flags[3];
                    5'd24: taken = m_flags[0];
                    default: taken = 1'b0;
                endcase
                if (taken) begin
                    e_pl = 1'b1; e_pt = ex.instr_mem_addr;
                end
                if (op inside {[1:10], [16:21], 25})
                    m_flags = {ex.zero_flag, ex.carry_flag, ex.ac_flag, ex.parity_flag};
            end
            tick();
            checks++; if ({reg_we, reg_waddr, reg_wdata} !== {e_rwe, e_ra, e_rd}) begin errors++; $display("FAIL rnd_reg n=%0d got %h want %h", n, {reg_we, reg_waddr, reg_wdata}, {e_rwe, e_ra, e_rd}); end
            checks++; if ({mem_we, mem_waddr, mem_wdata} !== {e_mwe, e_ma, e_md}) begin errors++; $display("FAIL rnd_mem n=%0d got %h want %h", n, {mem_we, mem_waddr, mem_wdata}, {e_mwe, e_ma, e_md}); end
            checks++; if ({pc_load, pc_target} !== {e_pl, e_pt}) begin errors++; $display("FAIL rnd_pc n=%0d got %h want %h", n, {pc_load, pc_target}, {e_pl, e_pt}); end
            checks++; if ({flags_q, retired, halted} !== {m_flags, m_ret, 1'b0}) begin errors++; $display("FAIL rnd_state n=%0d got %h want %h", n, {flags_q, retired, halted}, {m_flags, m_ret, 1'b0}); end
        end
        drive(1'b0, 5'd0, 1'b0, 3'd0, 4'd0, 6'd0, 16'd0, 4'd0);
        repeat (2) tick();
    endtask

    task automatic test_halt();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 5'b00000, 1'b0, 3'd4, 4'd0, 6'd0, 16'h0077, 4'b0000);
        tick();
        drive(1'b1, 5'b11111, 1'b0, 3'd4, 4'd0, 6'd0, 16'h0000, 4'b0000);
        tick();
        checks++; if ({halted, reg_we, retired, ex.in_ready} !== {1'b1, 1'b0, 8'd1, 1'b0}) begin errors++; $display("FAIL halt_enter got %h want %h", {halted, reg_we, retired, ex.in_ready}, {1'b1, 1'b0, 8'd1, 1'b0}); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k[0] ? 5'b01101 : 5'b00001), k[1], 3'd5, 4'd2, 6'h11, 16'h00EE, 4'b1111);
            tick();
            checks++; if ({reg_we, mem_we, pc_load, halted, retired, flags_q} !== {4'b0001, 8'd1, 4'b0000}) begin errors++; $display("FAIL halt_ignore k=%0d got %h want %h", k, {reg_we, mem_we, pc_load, halted, retired, flags_q}, {4'b0001, 8'd1, 4'b0000}); end
        end
        reset = 1'b1;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset got %b want 0", halted); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_wide();
        test_mem();
        test_branch();
        test_reset_mid_wide();
        test_random();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
